parallel_masked_sequence_detection: RTL and testbench
=====================================================

Name: parallel_masked_sequence_detection

Overview:
Streaming successor to the parallel sequence detector. It scans a WID_Bitstream-bit-per-beat byte/bit stream for a WID_Compair-bit pattern with a per-bit don't-care mask, and advances only on valid beats so the upstream can stall. Per beat it reports every match offset and the match count. It also keeps a saturating per-stream total and signals end of stream. It sits between the stream deframer and the statistics/control logic.

Parameters:
WID_Bitstream, 8, bits per beat; number of match offsets checked per beat.
WID_Compair, 12, pattern and mask width, >=1.
WID_Compair_count, 4, per-beat count width, >= $clog2(WID_Bitstream+1).
WID_Total, 16, per-stream accumulated match total width.

Ports:
local_PMSD_clk  in  1  clock, rising edge.
local_PMSD_reset  in  1  asynchronous, active-high reset.
local_PMSD_newstream  in  1  single-cycle start pulse; loads pattern/mask and clears state.
local_PMSD_compair  in  WID_Compair  pattern, sampled on newstream.
local_PMSD_mask  in  WID_Compair  1 = compare bit, 0 = don't care; sampled on newstream.
local_PMSD_valid  in  1  beat present on bitstream.
local_PMSD_bitstream  in  WID_Bitstream  beat data; newest data lands in buffer LSBs.
local_PMSD_last  in  1  qualifies the final beat of the stream; meaningful only with valid.
PMSD_local_busy  out  1  high while state != IDLE.
PMSD_local_valid  out  1  one-cycle pulse: position/count valid.
PMSD_local_position  out  WID_Bitstream  bit i = match at offset i.
PMSD_local_count  out  WID_Compair_count  popcount of position.
PMSD_local_total  out  WID_Total  saturating sum of counts for the current stream.
PMSD_local_overflow  out  1  sticky; total saturated.
PMSD_local_done  out  1  one-cycle end-of-stream pulse.

Behaviour:
- Reset (async) values: state IDLE, all outputs 0, pattern/mask/buffer 0.
- Buffer:
  - NUM_Buffer = ceil((WID_Compair+WID_Bitstream-1)/WID_Bitstream) beats.
  - Shifts left by WID_Bitstream only on an accepted beat.
  - A beat is accepted when valid is high, newstream is low and state != IDLE.
- Match rule for offset i: ((buf[i+WID_Compair-1:i] ^ pattern) & mask) == 0. With mask 0, every offset matches.
- NUM_Fill = ceil((WID_Compair-1)/WID_Bitstream); this is 0 when WID_Compair=1.
- FSM states: IDLE, FILLING, MATCHING.
  - newstream, from any state: clear buffer, total, overflow, position and count. Load pattern and mask. Go to FILLING with fill counter = NUM_Fill, or directly to MATCHING if NUM_Fill=0.
  - newstream has priority over a simultaneous valid/last. That beat is dropped, and no done is raised for the aborted stream.
  - FILLING: each accepted beat decrements the counter and produces no result. When the counter reaches 0 after a beat, go to MATCHING.
  - FILLING + accepted beat with last: done=1 next cycle, valid stays 0, total stays 0, go to IDLE.
  - MATCHING, accepted beat: next cycle valid=1, position and count updated, total += count (saturating).
  - MATCHING + accepted beat with last: same result, plus done=1 in the same cycle as its valid, then IDLE.
  - IDLE: valid and last are ignored.
- Latency: 1 cycle from accepted beat to result. Stall cycles (valid=0) freeze the buffer and leave the outputs holding their values; the valid pulse is not repeated.
- Total: if the sum exceeds 2^WID_Total-1, clamp to all-ones and set overflow. Overflow stays set until newstream or reset.
- Position, count and total hold after done until the next newstream.
- Reset mid-stream returns the block to reset values immediately; no done is raised.

Test Plan:
1. Defaults. newstream with pattern 12'h005, mask 12'h00F; three beats of 8'h55 -> valid on the 3rd beat only: position 8'h55, count 4, total 4. A 4th beat -> total 8.
2. Pattern 12'hABC, mask 12'hFFF; beats 8'h00, 8'hAB, 8'hC0 -> position 8'h10, count 1.
3. Case 1 stimulus with 3 idle cycles inserted between beats -> identical results; valid pulses exactly once per matching beat.
4. WID_Total=4; pattern 0, mask 12'hFFF, all-zero beats -> each result count 8. Total 8, then 15 with overflow=1; total stays 15 afterwards.
5. newstream, then 2 beats with last on the 2nd -> done pulses, valid never asserted, total 0, busy drops to 0.
6. Reset asserted mid-MATCHING while valid beats continue, or newstream coinciding with valid+last -> all outputs 0 on reset / counters cleared on newstream, no done, the coinciding beat not counted.

Source files
------------

// File: rtl/parallel_masked_sequence_detection.sv
// Streaming masked pattern detector: checks every offset of each accepted beat
// against a pattern with per-bit don't-care mask, reporting position, count and a saturating total.
module parallel_masked_sequence_detection #(
  parameter int WID_Bitstream     = 8,
  parameter int WID_Compair       = 12,
  parameter int WID_Compair_count = 4,
  parameter int WID_Total         = 16
) (
  input  logic                         local_PMSD_clk,
  input  logic                         local_PMSD_reset,
  input  logic                         local_PMSD_newstream,
  input  logic [WID_Compair-1:0]       local_PMSD_compair,
  input  logic [WID_Compair-1:0]       local_PMSD_mask,
  input  logic                         local_PMSD_valid,
  input  logic [WID_Bitstream-1:0]     local_PMSD_bitstream,
  input  logic                         local_PMSD_last,
  output logic                         PMSD_local_busy,
  output logic                         PMSD_local_valid,
  output logic [WID_Bitstream-1:0]     PMSD_local_position,
  output logic [WID_Compair_count-1:0] PMSD_local_count,
  output logic [WID_Total-1:0]         PMSD_local_total,
  output logic                         PMSD_local_overflow,
  output logic                         PMSD_local_done
);

  localparam int NUM_FILL = (WID_Compair + WID_Bitstream - 2) / WID_Bitstream;
  localparam int FILL_W   = (NUM_FILL > 0) ? $clog2(NUM_FILL + 1) : 1;
  localparam int HIST_W   = (WID_Compair > 1) ? WID_Compair - 1 : 1;
  localparam int WIN_W    = WID_Compair + WID_Bitstream - 1;

  typedef enum logic [1:0] {IDLE, FILLING, MATCHING} state_e;

  state_e state_q, state_d;
  logic [FILL_W-1:0]            fill_q, fill_d;
  logic [WID_Compair-1:0]       pat_q, pat_d, mask_q, mask_d;
  logic [HIST_W-1:0]            hist_q, hist_d, hist_next;
  logic [WIN_W-1:0]             window;
  logic [WID_Bitstream-1:0]     match;
  logic [WID_Bitstream-1:0]     pos_q, pos_d;
  logic [WID_Compair_count-1:0] cnt_q, cnt_d, match_cnt;
  logic [WID_Total-1:0]         total_q, total_d;
  logic [WID_Total:0]           sum;
  logic                         ovf_q, ovf_d, valid_q, valid_d, done_q, done_d;
  logic                         accept;

  // Only the newest WID_Compair-1 bits are kept between beats; older buffer
  // bits can never fall inside a match window, so storing them is pointless.
  if (WID_Compair > 1) begin : g_hist
    assign window    = {hist_q, local_PMSD_bitstream};
    assign hist_next = window[HIST_W-1:0];
  end else begin : g_nohist
    assign window    = local_PMSD_bitstream;
    assign hist_next = '0;
  end

  function automatic logic [WID_Compair_count-1:0] popcount(input logic [WID_Bitstream-1:0] v);
    logic [WID_Compair_count-1:0] c;
    c = '0;
    for (int i = 0; i < WID_Bitstream; i++) c = c + WID_Compair_count'(v[i]);
    return c;
  endfunction

  assign accept = local_PMSD_valid && !local_PMSD_newstream && (state_q != IDLE);

  always_comb begin
    match = '0;
    for (int i = 0; i < WID_Bitstream; i++)
      match[i] = (((window[i +: WID_Compair] ^ pat_q) & mask_q) == '0);
    match_cnt = popcount(match);
    sum       = {1'b0, total_q} + (WID_Total + 1)'(match_cnt);
  end

  // State register
  always_ff @(posedge local_PMSD_clk or posedge local_PMSD_reset) begin
    if (local_PMSD_reset) state_q <= IDLE;
    else                  state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (local_PMSD_newstream) begin
      state_d = (NUM_FILL == 0) ? MATCHING : FILLING;
    end else if (accept) begin
      if (local_PMSD_last)                                   state_d = IDLE;
      else if (state_q == FILLING && fill_q == FILL_W'(1))   state_d = MATCHING;
    end
  end

  // Output logic
  always_comb begin
    PMSD_local_busy = (state_q != IDLE);
  end

  // Datapath next values
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
    fill_d  = fill_q;
    pat_d   = pat_q;
    mask_d  = mask_q;
    hist_d  = hist_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    total_d = total_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (local_PMSD_newstream) begin
      fill_d  = FILL_W'(NUM_FILL);
      pat_d   = local_PMSD_compair;
      mask_d  = local_PMSD_mask;
      hist_d  = '0;
      pos_d   = '0;
      cnt_d   = '0;
      total_d = '0;
      ovf_d   = 1'b0;
    end else if (accept) begin
      hist_d = hist_next;
      done_d = local_PMSD_last;
      if (state_q == FILLING) begin
        fill_d = fill_q - FILL_W'(1);
      end else begin
        valid_d = 1'b1;
        pos_d   = match;
        cnt_d   = match_cnt;
        total_d = sum[WID_Total] ? '1 : sum[WID_Total-1:0];
        ovf_d   = ovf_q | sum[WID_Total];
      end
    end
  end

  // NOTE: the history register is a few flops, not a RAM, so it is reset with everything else.
  always_ff @(posedge local_PMSD_clk or posedge local_PMSD_reset) begin
    if (local_PMSD_reset) begin
      fill_q  <= '0;
      pat_q   <= '0;
      mask_q  <= '0;
      hist_q  <= '0;
      pos_q   <= '0;
      cnt_q   <= '0;
      total_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      mask_q  <= mask_d;
      hist_q  <= hist_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign PMSD_local_valid    = valid_q;
  assign PMSD_local_position = pos_q;
  assign PMSD_local_count    = cnt_q;
  assign PMSD_local_total    = total_q;
  assign PMSD_local_overflow = ovf_q;
  assign PMSD_local_done     = done_q;

endmodule

// File: tb/tb_parallel_masked_sequence_detection.sv
// Scoreboard bench: directed beats push expected results; monitors pop on valid/done.
module tb_parallel_masked_sequence_detection;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic [7:0]  pos;
    logic [3:0]  cnt;
    logic [15:0] total;
    logic        ovf;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance (16-bit total) and narrow-total instance (4-bit total)
  logic        ns [2];
  logic [11:0] cp [2];
  logic [11:0] mk [2];
  logic        vin [2];
  logic [7:0]  bits [2];
  logic        last [2];

  logic        busy16, valid16, ovf16, done16;
  logic [7:0]  pos16;
  logic [3:0]  cnt16;
  logic [15:0] total16;
  logic        busy4, valid4, ovf4, done4;
  logic [7:0]  pos4;
  logic [3:0]  cnt4;
  logic [3:0]  total4;

  parallel_masked_sequence_detection dut (
    .local_PMSD_clk(clk), .local_PMSD_reset(rst),
    .local_PMSD_newstream(ns[0]), .local_PMSD_compair(cp[0]), .local_PMSD_mask(mk[0]),
    .local_PMSD_valid(vin[0]), .local_PMSD_bitstream(bits[0]), .local_PMSD_last(last[0]),
    .PMSD_local_busy(busy16), .PMSD_local_valid(valid16), .PMSD_local_position(pos16),
    .PMSD_local_count(cnt16), .PMSD_local_total(total16), .PMSD_local_overflow(ovf16),
    .PMSD_local_done(done16)
  );

  parallel_masked_sequence_detection #(.WID_Total(4)) dut4 (
    .local_PMSD_clk(clk), .local_PMSD_reset(rst),
    .local_PMSD_newstream(ns[1]), .local_PMSD_compair(cp[1]), .local_PMSD_mask(mk[1]),
    .local_PMSD_valid(vin[1]), .local_PMSD_bitstream(bits[1]), .local_PMSD_last(last[1]),
    .PMSD_local_busy(busy4), .PMSD_local_valid(valid4), .PMSD_local_position(pos4),
    .PMSD_local_count(cnt4), .PMSD_local_total(total4), .PMSD_local_overflow(ovf4),
    .PMSD_local_done(done4)
  );

  int tests = 0;
  int fails = 0;
  resp_t q16[$];
  resp_t q4[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic resp_t mkr(input logic v, input logic d, input logic [7:0] p,
                                input logic [3:0] c, input logic [15:0] t, input logic o);
    resp_t r;
    r.valid = v; r.done = d; r.pos = p; r.cnt = c; r.total = t; r.ovf = o;
    return r;
  endfunction

  // Monitors: compare whenever a DUT presents valid or done
  initial forever begin
    resp_t a, e;
    @(negedge clk);
    if (!rst && (valid16 || done16)) begin
      a = mkr(valid16, done16, pos16, cnt16, total16, ovf16);
      if (q16.size() == 0) check("sb16_unexpected", {1'b0, a}, 32'h0);
      else begin e = q16.pop_front(); check("sb16", {1'b0, a}, {1'b0, e}); end
    end
  end

  initial forever begin
    resp_t a, e;
    @(negedge clk);
    if (!rst && (valid4 || done4)) begin
      a = mkr(valid4, done4, pos4, cnt4, {12'h0, total4}, ovf4);
      if (q4.size() == 0) check("sb4_unexpected", {1'b0, a}, 32'h0);
      else begin e = q4.pop_front(); check("sb4", {1'b0, a}, {1'b0, e}); end
    end
  end

  task automatic start(input int s, input logic [11:0] pat, input logic [11:0] msk);
    ns[s] = 1'b1; cp[s] = pat; mk[s] = msk;
    @(posedge clk); #1;
    ns[s] = 1'b0;
  endtask

  task automatic beat(input int s, input logic [7:0] d, input logic l);
    vin[s] = 1'b1; bits[s] = d; last[s] = l;
    @(posedge clk); #1;
    vin[s] = 1'b0; last[s] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      ns[s] = 0; cp[s] = 0; mk[s] = 0; vin[s] = 0; bits[s] = 0; last[s] = 0;
    end
    idle(2);
    check("rst_busy", busy16, 0);
    check("rst_outs", {valid16, done16, ovf16, pos16, cnt16, total16}, 0);
    check("rst_outs4", {busy4, valid4, done4, ovf4, pos4, cnt4, total4}, 0);
    @(negedge clk); rst = 1'b0;
    idle(1);

    // Default masked match with a fourth beat accumulating
    start(0, 12'h005, 12'h00F);
    check("t1_busy", busy16, 1);
    beat(0, 8'h55, 0);
    beat(0, 8'h55, 0);
    q16.push_back(mkr(1, 0, 8'h55, 4, 4, 0));
    beat(0, 8'h55, 0);
    q16.push_back(mkr(1, 0, 8'h55, 4, 8, 0));
    beat(0, 8'h55, 0);
    idle(2);
    check("t1_hold_total", total16, 8);
    check("t1_valid_low", valid16, 0);

    // Same stream with stalls between beats
    start(0, 12'h005, 12'h00F);
    check("t3_cleared", {pos16, cnt16, total16}, 0);
    for (int k = 0; k < 4; k++) begin
      if (k == 2) q16.push_back(mkr(1, 0, 8'h55, 4, 4, 0));
      if (k == 3) q16.push_back(mkr(1, 0, 8'h55, 4, 8, 0));
      beat(0, 8'h55, 0);
      idle(3);
    end
    check("t3_hold", {pos16, cnt16, total16}, {8'h55, 4'd4, 16'd8});

    // Full-mask pattern straddling beats, ended with last
    start(0, 12'hABC, 12'hFFF);
    beat(0, 8'h00, 0);
    beat(0, 8'hAB, 0);
    q16.push_back(mkr(1, 1, 8'h10, 1, 1, 0));
    beat(0, 8'hC0, 1);
    idle(1);
    check("t2_idle", busy16, 0);
    beat(0, 8'hFF, 1);
    idle(2);
    check("t2_hold_after_done", {pos16, cnt16, total16}, {8'h10, 4'd1, 16'd1});

    // Stream ending during fill
    start(0, 12'h005, 12'h00F);
    beat(0, 8'h55, 0);
    q16.push_back(mkr(0, 1, 8'h00, 0, 0, 0));
    beat(0, 8'h55, 1);
    idle(1);
    check("t5_busy", busy16, 0);
    check("t5_total", total16, 0);

    // newstream coinciding with valid+last
    start(0, 12'h005, 12'h00F);
    beat(0, 8'h55, 0);
    beat(0, 8'h55, 0);
    q16.push_back(mkr(1, 0, 8'h55, 4, 4, 0));
    beat(0, 8'h55, 0);
    ns[0] = 1'b1; vin[0] = 1'b1; last[0] = 1'b1; bits[0] = 8'h55;
    @(posedge clk); #1;
    ns[0] = 1'b0; vin[0] = 1'b0; last[0] = 1'b0;
    idle(1);
    check("t6_ns_cleared", {pos16, cnt16, total16}, 0);
    check("t6_ns_busy", busy16, 1);
    beat(0, 8'h55, 0);
    beat(0, 8'h55, 0);
    q16.push_back(mkr(1, 0, 8'h55, 4, 4, 0));
    beat(0, 8'h55, 0);
    q16.push_back(mkr(1, 0, 8'h55, 4, 8, 0));
    beat(0, 8'h55, 0);

    // Reset mid-MATCHING with beats still arriving
    @(negedge clk); #1;
    vin[0] = 1'b1; bits[0] = 8'h55;
    rst = 1'b1;
    #1;
    check("t6_rst_outs", {busy16, valid16, done16, ovf16, pos16, cnt16, total16}, 0);
    idle(2);
    @(negedge clk);
    vin[0] = 1'b0;
    rst = 1'b0;
    idle(2);
    check("t6_after_rst", {busy16, total16}, 0);

    // Saturation on the narrow-total instance
    start(1, 12'h000, 12'hFFF);
    beat(1, 8'h00, 0);
    beat(1, 8'h00, 0);
    q4.push_back(mkr(1, 0, 8'hFF, 8, 8, 0));
    beat(1, 8'h00, 0);
    q4.push_back(mkr(1, 0, 8'hFF, 8, 15, 1));
    beat(1, 8'h00, 0);
    q4.push_back(mkr(1, 0, 8'hFF, 8, 15, 1));
    beat(1, 8'h00, 0);
    idle(2);
    check("t4_sat", {ovf4, total4}, {1'b1, 4'hF});

    idle(2);
    check("q16_drained", q16.size(), 0);
    check("q4_drained", q4.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
